// File: rtl/serdes_frame_ctrl_if.sv
// serdes_frame_ctrl_if: serial line input and aligned parallel output bundle
//   master: drives ser_in/ser_en/resync/err_clr, observes the parallel side
//   slave : the framing controller
interface serdes_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             ser_in;
    logic             ser_en;
    logic             resync;
    logic             err_clr;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             frame_start;
    logic             locked;
    logic             sync_err;
    logic             lock_lost;
    logic [7:0]       err_cnt;
    modport master (
        output ser_in, ser_en, resync, err_clr,
        input  par_out, par_valid, frame_start, locked, sync_err, lock_lost, err_cnt
    );
    modport slave (
        input  ser_in, ser_en, resync, err_clr,
        output par_out, par_valid, frame_start, locked, sync_err, lock_lost, err_cnt
    );
endinterface

// File: rtl/serdes_frame_ctrl.sv
// serdes_frame_ctrl: sync-word hunt, frame verify/lock and aligned word output
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   bus.ser_in  : serial bit, MSB of each word first, qualified by bus.ser_en
//   bus.resync  : return to HUNT on the next edge; bus.err_clr clears err_cnt
//   bus.par_out/par_valid : aligned data word and its one-cycle strobe
//   bus.frame_start/sync_err/lock_lost : one-cycle event pulses while locked
//   bus.locked  : high in LOCKED; bus.err_cnt : saturating sync_err count
module serdes_frame_ctrl #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 'hA5,
    parameter int               FRAME_WORDS = 4,
    parameter int               LOCK_COUNT  = 2,
    parameter int               LOSS_COUNT  = 4
) (
    input logic               clk,
    input logic               reset,
    serdes_frame_ctrl_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int WW = $clog2(FRAME_WORDS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, nxt, par_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [WW-1:0]    word_cnt, word_n;
    logic [3:0]       match_cnt, match_n, miss_cnt, miss_n;
    logic [7:0]       err_n;
    logic             valid_n, fs_n, se_n, ll_n, drop;
    logic             word_done, sync_hit, sync_slot;

    assign nxt       = {shreg[WIDTH-2:0], bus.ser_in};
    assign word_done = bit_cnt == BIT_LAST;
    assign sync_hit  = nxt == SYNC_WORD;
    assign sync_slot = word_done && word_cnt == '0;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        word_n  = word_cnt;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        par_n   = bus.par_out;
        valid_n = 1'b0;
        fs_n    = 1'b0;
        se_n    = 1'b0;
        ll_n    = 1'b0;
        drop    = bus.resync;
        if (!bus.resync && bus.ser_en) begin
            shreg_n = nxt;
            bit_n   = word_done ? '0 : bit_cnt + 1'b1;
            word_n  = !word_done ? word_cnt : word_cnt == WORD_LAST ? '0 : word_cnt + 1'b1;
            case (state)
                HUNT: begin
                    // bit_cnt counts bits shifted in since entering HUNT and
                    // saturates, so stale or cleared bits never form a match
                    bit_n  = word_done ? bit_cnt : bit_cnt + 1'b1;
                    word_n = '0;
                    if (word_done && sync_hit) begin
                        state_n = VERIFY;
                        bit_n   = '0;
                        word_n  = WW'(1);
                        match_n = '0;
                    end
                end
                VERIFY: if (sync_slot) begin
                    match_n = match_cnt + 4'd1;
                    drop    = !sync_hit;
                    if (sync_hit && match_n == 4'(LOCK_COUNT)) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                    end
                end
                LOCKED: if (word_done) begin
                    if (!sync_slot) begin
                        par_n   = nxt;
                        valid_n = 1'b1;
                    end else if (sync_hit) begin
                        fs_n   = 1'b1;
                        miss_n = '0;
                    end else begin
                        // alignment is kept across isolated misses
                        se_n   = 1'b1;
                        miss_n = miss_cnt + 4'd1;
                        ll_n   = miss_n == 4'(LOSS_COUNT);
                        drop   = ll_n;
                    end
                end
                default: drop = 1'b1;
            endcase
        end
        // returning to HUNT flushes the shifter so the rejected bits are not rescanned
        if (drop) begin
            state_n = HUNT;
            shreg_n = '0;
            bit_n   = '0;
            word_n  = '0;
            match_n = '0;
            miss_n  = '0;
        end
        err_n = bus.err_clr ? {7'd0, se_n} : se_n && bus.err_cnt != 8'hFF ? bus.err_cnt + 8'd1 : bus.err_cnt;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state           <= HUNT;
            shreg           <= '0;
            bit_cnt         <= '0;
            word_cnt        <= '0;
            match_cnt       <= '0;
            miss_cnt        <= '0;
            bus.par_out     <= '0;
            bus.par_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.sync_err    <= 1'b0;
            bus.lock_lost   <= 1'b0;
            bus.locked      <= 1'b0;
            bus.err_cnt     <= '0;
        end else begin
            state           <= state_n;
            shreg           <= shreg_n;
            bit_cnt         <= bit_n;
            word_cnt        <= word_n;
            match_cnt       <= match_n;
            miss_cnt        <= miss_n;
            bus.par_out     <= par_n;
            bus.par_valid   <= valid_n;
            bus.frame_start <= fs_n;
            bus.sync_err    <= se_n;
            bus.lock_lost   <= ll_n;
            bus.locked      <= state_n == LOCKED;
            bus.err_cnt     <= err_n;
        end
endmodule

// File: tb/tb_serdes_frame_ctrl.sv
// tb_serdes_frame_ctrl: randomized framing stimulus checked cycle by cycle against a frame-level model
module tb_serdes_frame_ctrl;
    localparam int         W    = 8;
    localparam int         FW   = 4;
    localparam int         LC   = 2;
    localparam int         LS   = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int M_HUNT = 0, M_VER = 1, M_LOCK = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    serdes_frame_ctrl_if #(.WIDTH(W)) bus ();

    serdes_frame_ctrl #(
        .WIDTH(W), .SYNC_WORD(SYNC), .FRAME_WORDS(FW), .LOCK_COUNT(LC), .LOSS_COUNT(LS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         mode, pos, hits, misses;
    logic       win[$];
    logic [W-1:0] cur, e_par;
    logic       e_valid, e_fs, e_se, e_ll, e_locked;
    logic [7:0] e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic hunt();
        mode = M_HUNT;
        win.delete();
    endtask

    task automatic model_reset();
        hunt();
        pos = 0; hits = 0; misses = 0; cur = '0;
        e_par = '0; e_valid = 0; e_fs = 0; e_se = 0; e_ll = 0; e_locked = 0; e_err = '0;
    endtask

    // frame-level view: position counted in bits since the sync word that started VERIFY
    task automatic model(input logic b, input logic en, input logic rs, input logic ec);
        logic [W-1:0] w;
        int slot;
        e_valid = 0; e_fs = 0; e_se = 0; e_ll = 0;
        if (rs) hunt();
        else if (en) begin
            if (mode == M_HUNT) begin
                win.push_back(b);
                if (win.size() > W) void'(win.pop_front());
                w = '0;
                foreach (win[i]) w = {w[W-2:0], win[i]};
                if (win.size() == W && w == SYNC) begin
                    mode = M_VER; pos = 0; hits = 0;
                end
            end else begin
                cur = {cur[W-2:0], b};
                pos++;
                if (pos % W == 0) begin
                    slot = (pos / W) % FW;
                    if (mode == M_VER) begin
                        if (slot == 0) begin
                            if (cur == SYNC) begin
                                hits++;
                                if (hits == LC) begin mode = M_LOCK; misses = 0; end
                            end else hunt();
                        end
                    end else if (slot != 0) begin
                        e_par = cur; e_valid = 1;
                    end else if (cur == SYNC) begin
                        e_fs = 1; misses = 0;
                    end else begin
                        e_se = 1; misses++;
                        if (misses == LS) begin e_ll = 1; hunt(); end
                    end
                end
            end
        end
        e_err = ec ? {7'd0, e_se} : (e_se && e_err != 8'hFF) ? e_err + 8'd1 : e_err;
        e_locked = mode == M_LOCK;
    endtask

    task automatic compare_all();
        check("par_out", 32'(bus.par_out), 32'(e_par));
        check("par_valid", 32'(bus.par_valid), 32'(e_valid));
        check("frame_start", 32'(bus.frame_start), 32'(e_fs));
        check("sync_err", 32'(bus.sync_err), 32'(e_se));
        check("lock_lost", 32'(bus.lock_lost), 32'(e_ll));
        check("locked", 32'(bus.locked), 32'(e_locked));
        check("err_cnt", 32'(bus.err_cnt), 32'(e_err));
    endtask

    task automatic step(input logic b, input logic en, input logic rs, input logic ec);
        @(negedge clk);
        bus.ser_in = b; bus.ser_en = en; bus.resync = rs; bus.err_clr = ec;
        @(posedge clk);
        #1;
        model(b, en, rs, ec);
        compare_all();
    endtask

    task automatic send_word(input logic [7:0] w, input int gap_pct, input logic ec_last);
        for (int i = W - 1; i >= 0; i--) begin
            for (int g = 0; g < 3 && int'($urandom_range(99, 0)) < gap_pct; g++)
                step(1'($urandom), 1'b0, 1'b0, 1'b0);
            step(w[i], 1'b1, 1'b0, ec_last && i == 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] sync, input int gap_pct, input logic ec_sync);
        send_word(sync, gap_pct, ec_sync);
        for (int k = 1; k < FW; k++) send_word(8'($urandom_range(255, 0)), gap_pct, 1'b0);
    endtask

    initial begin
        bus.ser_in = 0; bus.ser_en = 0; bus.resync = 0; bus.err_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        @(negedge clk) reset = 1'b0;
        // false sync: sliding A5 followed by a non-sync word at the frame period
        for (int i = 0; i < 13; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        send_word(SYNC, 0, 1'b0);
        for (int k = 1; k < FW; k++) send_word(8'($urandom_range(255, 0)), 0, 1'b0);
        send_word(8'h3C, 0, 1'b0);
        // lock acquisition on a fixed pattern
        repeat (6) begin
            send_word(SYNC, 0, 1'b0);
            send_word(8'h11, 0, 1'b0);
            send_word(8'h22, 0, 1'b0);
            send_word(8'h33, 0, 1'b0);
        end
        check("locked_after_acq", 32'(bus.locked), 32'd1);
        // flywheel: one bad sync
        send_frame(8'hA4, 0, 1'b0);
        check("flywheel_err_cnt", 32'(bus.err_cnt), 32'd1);
        repeat (2) send_frame(SYNC, 0, 1'b0);
        // loss of lock
        repeat (LS) send_frame(8'hA4, 0, 1'b0);
        check("loss_unlocked", 32'(bus.locked), 32'd0);
        repeat (2) send_frame(SYNC, 0, 1'b0);
        // relock through random ser_en gaps
        repeat (6) send_frame(SYNC, 30, 1'b0);
        // resync mid-frame
        for (int i = 0; i < 12; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        step(1'($urandom), 1'b1, 1'b1, 1'b0);
        repeat (6) send_frame(SYNC, 20, 1'b0);
        // err_clr coincident with sync_err
        send_frame(8'hA4, 0, 1'b1);
        send_frame(SYNC, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) send_frame(SYNC, 10, 1'b0);
        // async reset mid-word
        for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.ser_en = 0;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk) reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) send_frame(SYNC, 0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serdes_frame_ctrl.md
Name: serdes_frame_ctrl

Overview:
- Framing and alignment controller for the serial-to-parallel datapath.
- Watches the raw serial bit stream and hunts for a sync word, then verifies the frame period and declares lock.
- Once locked, sequences word boundaries and emits aligned parallel data words with a valid strobe; sync slots are removed from the output.
- Tracks sync errors and drops lock after repeated misses. Sits between the serial line input and downstream parallel consumers.

Parameters:
- WIDTH, 8: bits per word (3..16).
- SYNC_WORD, 8'hA5: alignment pattern, WIDTH bits, MSB first on the line.
- FRAME_WORDS, 4: words per frame including the sync word (2..256).
- LOCK_COUNT, 2: further consecutive sync matches needed in VERIFY after the initial hit (1..15).
- LOSS_COUNT, 4: consecutive sync misses in LOCKED that drop lock (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ser_in  in  1  serial data bit, MSB of each word first.
- ser_en  in  1  qualifies ser_in; when low, nothing advances.
- resync  in  1  synchronous request to return to HUNT.
- err_clr  in  1  synchronous clear of err_cnt.
- par_out  out  WIDTH  aligned data word (registered).
- par_valid  out  1  one-cycle pulse, par_out valid.
- frame_start  out  1  one-cycle pulse on sync matched while LOCKED.
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle pulse on sync mismatch while LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition caused by misses.
- err_cnt  out  8  saturating count of sync_err pulses.

Behaviour:
- Reset (async) state and outputs:
  - state=HUNT; shift register, bit_cnt, word_cnt, match/miss counters = 0.
  - par_out=0, all pulses=0, locked=0, err_cnt=0.
- Shift register:
  - On ser_en: nxt = {shreg[WIDTH-2:0], ser_in}; shreg <= nxt.
  - A word completes on an ser_en cycle with bit_cnt==WIDTH-1; bit_cnt then wraps to 0.
  - word_cnt increments per completed word and wraps FRAME_WORDS-1 -> 0. Slot 0 is the sync slot.
- HUNT:
  - Each ser_en cycle, compare nxt to SYNC_WORD. This check is bitwise sliding, not word-aligned.
  - On match: go to VERIFY with bit_cnt=0, word_cnt=1, match_cnt=0.
- VERIFY:
  - Data slots are not output.
  - At a completed slot-0 word: if nxt==SYNC_WORD, increment match_cnt; when it reaches LOCK_COUNT, go to LOCKED with miss_cnt=0.
  - Mismatch -> HUNT. Counters clear, and the mismatching word is not rescanned.
- LOCKED:
  - Completed data word (slot != 0): par_out<=nxt and par_valid=1 on the next cycle, i.e. 1-cycle latency after the last bit is sampled.
  - Completed slot-0 word, match: frame_start pulse, miss_cnt=0.
  - Completed slot-0 word, mismatch: sync_err pulse, err_cnt+1 (saturate at 255), miss_cnt+1. When miss_cnt reaches LOSS_COUNT: lock_lost pulse, go to HUNT.
  - Alignment is unchanged on a single miss (flywheel).
- locked is registered; it goes high the cycle after the LOCK_COUNT-th verify match and low the cycle after the transition to HUNT.
- par_out holds its last value between pulses and is never updated outside LOCKED.
- resync high: on the next edge go to HUNT, clear counters and all pulses. Priority: reset > resync > normal operation. lock_lost is not pulsed on resync.
- err_clr: err_cnt<=0. If err_clr and sync_err occur in the same cycle, err_cnt<=1.
- ser_en low: all counters and shreg hold, no pulses. Gaps may appear mid-word.
- Asynchronous reset mid-frame aborts immediately; the partial word is discarded.

Test Plan:
- Lock acquisition: FRAME_WORDS=4, LOCK_COUNT=2; stream frames {A5,11,22,33} continuously, ser_en=1 -> locked rises 1 cycle after the third sync is sampled. From the next frame, par_valid pulses carry 11, 22, 33, and frame_start pulses every 32 cycles.
- False sync: a random prefix contains A5 at an arbitrary bit offset, followed by a non-A5 word at the frame period -> returns to HUNT, locked stays 0, then locks on the real stream.
- Flywheel: while locked, corrupt one sync word to A4 -> one sync_err pulse, err_cnt=1, locked stays 1, the following data words still valid.
- Loss of lock: LOSS_COUNT=4; corrupt 4 consecutive sync words -> sync_err x4, lock_lost pulse, locked=0, err_cnt=4. Data words after the loss are not output.
- ser_en gaps: insert random ser_en=0 cycles mid-word -> identical par_out sequence to the gap-free run; no pulses during the gaps.
- Reset/resync: assert reset mid-word while locked -> all outputs 0 immediately. Pulse resync while locked -> HUNT next cycle, no lock_lost. err_clr coincident with sync_err -> err_cnt=1.
